// File: rtl/trigger_toggle_tx.sv
// trigger_toggle_tx: converts per-channel request pulses into level toggles,
//   spacing toggles by a holdoff interval and queueing requests that arrive
//   while a channel is blocked. Optional overflow flags: TRIGGER_TX_OVF_EN.
// Ports: clk, rst_n (async active-low) | pulse_in[N] requests |
//   toggle_out[N] registered toggle levels | busy_out[N] hold/backlog status |
//   ovf_out[N], clr_ovf[N] sticky lost-request flag and its clear (macro only).
// Latency: pulse in IDLE with no backlog toggles on the edge ending that cycle.
module trigger_toggle_tx #(
  parameter int TRIGGER_NUM = 7,
  parameter int HOLDOFF     = 3,
  parameter int PEND_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TRIGGER_NUM-1:0] pulse_in,
  output logic [TRIGGER_NUM-1:0] toggle_out,
  output logic [TRIGGER_NUM-1:0] busy_out
`ifdef TRIGGER_TX_OVF_EN
  ,
  output logic [TRIGGER_NUM-1:0] ovf_out,
  input  logic [TRIGGER_NUM-1:0] clr_ovf
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // HOLD lasts HOLDOFF cycles: load HOLDOFF-1, leave on the edge where it is 0.
  localparam logic [7:0]        HOLD_LOAD = 8'(HOLDOFF - 1);
  localparam logic [7:0]        HOLD_ONE  = 8'd1;
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

  for (genvar g = 0; g < TRIGGER_NUM; g++) begin : g_ch
    state_t            state, state_nxt;
    logic [7:0]        holdoff, holdoff_nxt;
    logic [PEND_W-1:0] pending, pending_nxt;
    logic              toggle, toggle_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= IDLE;
        holdoff <= '0;
        pending <= '0;
        toggle  <= 1'b0;
      end else begin
        state   <= state_nxt;
        holdoff <= holdoff_nxt;
        pending <= pending_nxt;
        toggle  <= toggle_nxt;
      end
    end

    always_comb begin
      state_nxt   = state;
      holdoff_nxt = holdoff;
      pending_nxt = pending;
      toggle_nxt  = toggle;
      case (state)
        IDLE: begin
          if (pulse_in[g] || (pending != '0)) begin
            toggle_nxt  = ~toggle;
            holdoff_nxt = HOLD_LOAD;
            state_nxt   = HOLD;
            // A fresh pulse alongside a backlog: one is consumed, one is
            // added, so the count stays put.
            if (!pulse_in[g]) begin
              pending_nxt = pending - PEND_ONE;
            end
          end
        end
        HOLD: begin
          if (holdoff == '0) begin
            state_nxt = IDLE;
          end else begin
            holdoff_nxt = holdoff - HOLD_ONE;
          end
          // Requests during HOLD (including the exit edge) are queued;
          // at full count they are dropped.
          if (pulse_in[g] && (pending != PEND_MAX)) begin
            pending_nxt = pending + PEND_ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    assign toggle_out[g] = toggle;
    assign busy_out[g]   = (state == HOLD) || (pending != '0);

`ifdef TRIGGER_TX_OVF_EN
    logic lost;
    logic ovf;

    assign lost = (state == HOLD) && pulse_in[g] && (pending == PEND_MAX);

    // Set has priority so a loss coinciding with a clear is never hidden.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf <= 1'b0;
      end else if (lost) begin
        ovf <= 1'b1;
      end else if (clr_ovf[g]) begin
        ovf <= 1'b0;
      end
    end

    assign ovf_out[g] = ovf;
`endif
  end

endmodule

// File: tb/tb_trigger_toggle_tx.sv
// tb_trigger_toggle_tx: self-checking bench for trigger_toggle_tx with default
//   parameters; table vectors, hand-written corner sequences and a randomized
//   run against a timing-based reference model plus an XOR change detector.
module tb_trigger_toggle_tx;
  localparam int TN   = 7;
  localparam int HO   = 3;
  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [TN-1:0] pulse_in = '0;
  logic [TN-1:0] clr_ovf = '0;
  logic [TN-1:0] toggle_out;
  logic [TN-1:0] busy_out;
  logic [TN-1:0] ovf_out;

  int n_checks = 0;
  int n_fail   = 0;

  trigger_toggle_tx #(.TRIGGER_NUM(TN), .HOLDOFF(HO), .PEND_W(PW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulse_in   (pulse_in),
    .toggle_out (toggle_out),
    .busy_out   (busy_out)
`ifdef TRIGGER_TX_OVF_EN
    ,
    .ovf_out    (ovf_out),
    .clr_ovf    (clr_ovf)
`endif
  );

`ifndef TRIGGER_TX_OVF_EN
  assign ovf_out = '0;
`endif

  always #5 clk = ~clk;

  // Downstream XOR change detector on the toggle levels.
  logic [TN-1:0] det_prev = '0;
  int            det_cnt  = 0;
  always @(posedge clk) begin
    det_cnt  <= det_cnt + $countones(toggle_out ^ det_prev);
    det_prev <= toggle_out;
  end

  // Reference model: a channel may toggle once more than HO cycles have
  // passed since its last toggle; otherwise requests go to a bounded backlog.
  int cyc;
  int last_tog[TN];
  int backlog[TN];
  int tog_cnt[TN];
  bit ovf_m[TN];

  function automatic bit ch_free(input int i);
    return (cyc - last_tog[i]) > HO;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TN; i++) begin
      last_tog[i] = -1000;
      backlog[i]  = 0;
      tog_cnt[i]  = 0;
      ovf_m[i]    = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic model_step(input logic [TN-1:0] p, input logic [TN-1:0] c);
    for (int i = 0; i < TN; i++) begin
      bit lost;
      lost = 1'b0;
      if (ch_free(i)) begin
        if (p[i] || backlog[i] > 0) begin
          tog_cnt[i]++;
          last_tog[i] = cyc;
          if (!p[i]) backlog[i]--;
        end
      end else if (p[i]) begin
        if (backlog[i] < PMAX) backlog[i]++;
        else lost = 1'b1;
      end
      if (lost) ovf_m[i] = 1'b1;
      else if (c[i]) ovf_m[i] = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Compare current outputs with the model, then apply this cycle's inputs.
  task automatic model_cycle(input logic [TN-1:0] p, input logic [TN-1:0] c);
    logic [TN-1:0] et, eb, eo;
    for (int i = 0; i < TN; i++) begin
      et[i] = tog_cnt[i][0];
      eb[i] = !ch_free(i) || (backlog[i] > 0);
      eo[i] = ovf_m[i];
    end
    check("rand_toggle", 32'(toggle_out), 32'(et));
    check("rand_busy", 32'(busy_out), 32'(eb));
`ifdef TRIGGER_TX_OVF_EN
    check("rand_ovf", 32'(ovf_out), 32'(eo));
`endif
    pulse_in = p;
    clr_ovf  = c;
    model_step(p, c);
    tick();
  endtask

  // Assert reset mid-cycle for two edges, check outputs, release after an edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n    = 1'b0;
    pulse_in = '0;
    clr_ovf  = '0;
    #1;
    check({tag, "_toggle"}, 32'(toggle_out), 32'h0);
    check({tag, "_busy"}, 32'(busy_out), 32'h0);
    check({tag, "_ovf"}, 32'(ovf_out), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [TN-1:0] p;
    logic [TN-1:0] t;
    logic [TN-1:0] b;
  } vec_t;

  initial begin
    vec_t          tbl[18];
    int            tcount;
    logic          prev_bit;
    logic [TN-1:0] p, c;
    int            det_start, exp_total;

    // cycle-by-cycle after release: {pulse driven, toggle seen, busy seen}
    tbl[0]  = '{7'h40, 7'h00, 7'h00};  // pulse in first cycle after release
    tbl[1]  = '{7'h01, 7'h40, 7'h40};
    tbl[2]  = '{7'h00, 7'h41, 7'h41};
    tbl[3]  = '{7'h00, 7'h41, 7'h41};
    tbl[4]  = '{7'h00, 7'h41, 7'h01};
    tbl[5]  = '{7'h02, 7'h41, 7'h00};
    tbl[6]  = '{7'h00, 7'h43, 7'h02};
    tbl[7]  = '{7'h00, 7'h43, 7'h02};
    tbl[8]  = '{7'h02, 7'h43, 7'h02};  // pulse on the HOLD->IDLE edge
    tbl[9]  = '{7'h00, 7'h43, 7'h02};
    tbl[10] = '{7'h00, 7'h41, 7'h02};
    tbl[11] = '{7'h00, 7'h41, 7'h02};
    tbl[12] = '{7'h00, 7'h41, 7'h02};
    tbl[13] = '{7'h7F, 7'h41, 7'h00};  // all channels at once
    tbl[14] = '{7'h00, 7'h3E, 7'h7F};
    tbl[15] = '{7'h00, 7'h3E, 7'h7F};
    tbl[16] = '{7'h00, 7'h3E, 7'h7F};
    tbl[17] = '{7'h00, 7'h3E, 7'h00};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_toggle", 32'(toggle_out), 32'h0);
    check("reset_busy", 32'(busy_out), 32'h0);
    check("reset_ovf", 32'(ovf_out), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      check("vec_toggle", 32'(toggle_out), 32'(tbl[i].t));
      check("vec_busy", 32'(busy_out), 32'(tbl[i].b));
      pulse_in = tbl[i].p;
      tick();
    end
    pulse_in = '0;

    // ch2 held high 20 cycles: backlog fills to 7, later requests are lost.
    tcount   = 0;
    prev_bit = toggle_out[2];
    for (int i = 0; i < 60; i++) begin
      if (toggle_out[2] != prev_bit) tcount++;
      prev_bit = toggle_out[2];
      pulse_in = (i < 20) ? 7'h04 : 7'h00;
      clr_ovf  = (i == 19 || i == 20) ? 7'h04 : 7'h00;
      tick();
`ifdef TRIGGER_TX_OVF_EN
      if (i == 19) check("ovf_set_wins_over_clr", 32'(ovf_out[2]), 32'h1);
      if (i == 20) check("ovf_cleared", 32'(ovf_out[2]), 32'h0);
`endif
    end
    clr_ovf = '0;
    if (toggle_out[2] != prev_bit) tcount++;
    check("saturate_toggle_count", 32'(tcount), 32'd12);
    check("saturate_drained_busy", 32'(busy_out), 32'h0);

    // ch3 backlog of 5 discarded by reset.
    for (int i = 0; i < 8; i++) begin
      pulse_in = (i < 7) ? 7'h08 : 7'h00;
      tick();
    end
    check("backlog_busy_before_reset", 32'(busy_out[3]), 32'h1);
    do_reset("mid_reset");
    for (int i = 0; i < 20; i++) begin
      check("post_reset_toggle", 32'(toggle_out), 32'h0);
      check("post_reset_busy", 32'(busy_out), 32'h0);
      tick();
    end

    // Randomized run against the model, with a dense burst to force losses.
    do_reset("rand_reset");
    tick();
    cyc       = 0;
    det_start = det_cnt;
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < TN; i++) begin
        p[i] = ($urandom_range(0, 99) < ((k >= 200 && k < 300) ? 95 : 30));
        c[i] = ($urandom_range(0, 99) < 5);
      end
      model_cycle(p, c);
    end
    for (int k = 0; k < 80; k++) model_cycle('0, '0);
    tick();
    exp_total = 0;
    for (int i = 0; i < TN; i++) exp_total += tog_cnt[i];
    check("loopback_detector_count", 32'(det_cnt - det_start), 32'(exp_total));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
